// File: rtl/commit_unit.sv
// commit_unit: in-order retirement buffer; out-of-order writeback, one commit per cycle.
module commit_unit #(
  parameter int WIDTH   = 31,
  parameter int A_WIDTH = 4,
  parameter int T_WIDTH = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               dispValid,
  input  logic [A_WIDTH:0]   dispDest,
  input  logic               dispWritesReg,
  output logic               dispReady,
  output logic [T_WIDTH:0]   dispTag,
  input  logic               wbValid,
  input  logic [T_WIDTH:0]   wbTag,
  input  logic [WIDTH:0]     wbData,
  input  logic               flush,
  output logic               regWrite,
  output logic [A_WIDTH:0]   wraddress,
  output logic [WIDTH:0]     wdata,
  output logic               validCommit,
  output logic [T_WIDTH:0]   commitTag,
  output logic [T_WIDTH+1:0] count
);
  localparam int DEPTH = 2 ** (T_WIDTH + 1);
  localparam logic [T_WIDTH+1:0] L_FULL = (T_WIDTH + 2)'(DEPTH);
  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   r_ready;
  logic [DEPTH-1:0]   r_wr;
  logic [A_WIDTH:0]   r_dest [DEPTH];
  logic [WIDTH:0]     r_data [DEPTH];
  logic [T_WIDTH:0]   r_head;
  logic [T_WIDTH:0]   r_tail;
  logic [T_WIDTH+1:0] r_count;
  logic               r_regWrite;
  logic               r_validCommit;
  logic [A_WIDTH:0]   r_wraddress;
  logic [WIDTH:0]     r_wdata;
  logic [T_WIDTH:0]   r_commitTag;
  logic               w_retire;
  logic               w_disp;
  assign dispReady   = r_count != L_FULL;
  assign dispTag     = r_tail;
  assign count       = r_count;
  assign regWrite    = r_regWrite;
  assign validCommit = r_validCommit;
  assign wraddress   = r_wraddress;
  assign wdata       = r_wdata;
  assign commitTag   = r_commitTag;
  // an empty buffer has no valid head, so no separate empty check is needed
  assign w_retire = r_valid[r_head] & r_ready[r_head];
  assign w_disp   = dispValid & dispReady;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_valid       <= '0;
      r_ready       <= '0;
      r_wr          <= '0;
      r_dest        <= '{default: '0};
      r_data        <= '{default: '0};
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_regWrite    <= 1'b0;
      r_validCommit <= 1'b0;
      r_wraddress   <= '0;
      r_wdata       <= '0;
      r_commitTag   <= '0;
    end else if (flush) begin
      r_valid       <= '0;
      r_ready       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_regWrite    <= 1'b0;
      r_validCommit <= 1'b0;
    end else begin
      if (wbValid && r_valid[wbTag]) begin
        r_ready[wbTag] <= 1'b1;
        r_data[wbTag]  <= wbData;
      end
      // retire clears after writeback so a late writeback to the head cannot revive it
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
        r_wraddress     <= r_dest[r_head];
        r_wdata         <= r_data[r_head];
        r_commitTag     <= r_head;
      end
      if (w_disp) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_wr[r_tail]    <= dispWritesReg;
        r_dest[r_tail]  <= dispDest;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= (w_disp && !w_retire) ? r_count + 1'b1 :
                 (!w_disp && w_retire) ? r_count - 1'b1 : r_count;
      r_validCommit <= w_retire;
      r_regWrite    <= w_retire && r_wr[r_head] && (r_dest[r_head] != '0);
    end
  end
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed vectors with hand-computed expectations for commit_unit.
module tb_commit_unit;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        dispValid = 1'b0;
  logic [4:0]  dispDest = '0;
  logic        dispWritesReg = 1'b0;
  logic        dispReady;
  logic [2:0]  dispTag;
  logic        wbValid = 1'b0;
  logic [2:0]  wbTag = '0;
  logic [31:0] wbData = '0;
  logic        flush = 1'b0;
  logic        regWrite;
  logic [4:0]  wraddress;
  logic [31:0] wdata;
  logic        validCommit;
  logic [2:0]  commitTag;
  logic [3:0]  count;
  int n_pass = 0;
  int n_total = 0;

  commit_unit dut (
    .clk(clk), .resetN(resetN), .dispValid(dispValid), .dispDest(dispDest),
    .dispWritesReg(dispWritesReg), .dispReady(dispReady), .dispTag(dispTag),
    .wbValid(wbValid), .wbTag(wbTag), .wbData(wbData), .flush(flush),
    .regWrite(regWrite), .wraddress(wraddress), .wdata(wdata),
    .validCommit(validCommit), .commitTag(commitTag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic commit_chk(input string tag, input logic rw, input logic [4:0] a,
                            input logic [31:0] d, input logic [2:0] t);
    chk({tag, ".validCommit"}, 64'(validCommit), 64'(1));
    chk({tag, ".regWrite"}, 64'(regWrite), 64'(rw));
    chk({tag, ".wraddress"}, 64'(wraddress), 64'(a));
    chk({tag, ".wdata"}, 64'(wdata), 64'(d));
    chk({tag, ".commitTag"}, 64'(commitTag), 64'(t));
  endtask

  task automatic disp(input logic [4:0] d, input logic w);
    dispValid = 1'b1; dispDest = d; dispWritesReg = w;
    tick();
    dispValid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] t, input logic [31:0] d);
    wbValid = 1'b1; wbTag = t; wbData = d;
    tick();
    wbValid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst.regWrite", 64'(regWrite), 64'(0));
    chk("rst.validCommit", 64'(validCommit), 64'(0));
    chk("rst.wraddress", 64'(wraddress), 64'(0));
    chk("rst.wdata", 64'(wdata), 64'(0));
    chk("rst.commitTag", 64'(commitTag), 64'(0));
    chk("rst.dispReady", 64'(dispReady), 64'(1));
    chk("rst.dispTag", 64'(dispTag), 64'(0));
    chk("rst.count", 64'(count), 64'(0));
    resetN = 1'b1;
    tick();
    // single instruction: dispatch, writeback, commit one edge later
    disp(5'd2, 1'b1);
    chk("t1.count", 64'(count), 64'(1));
    wb(3'd0, 32'd5);
    chk("t1.noEarly", 64'(validCommit), 64'(0));
    tick();
    commit_chk("t1", 1'b1, 5'd2, 32'd5, 3'd0);
    chk("t1.countAfter", 64'(count), 64'(0));
    tick();
    chk("t1.pulse", 64'(validCommit), 64'(0));
    chk("t1.rwLow", 64'(regWrite), 64'(0));
    chk("t1.holdAddr", 64'(wraddress), 64'(2));
    chk("t1.holdData", 64'(wdata), 64'(5));
    // out-of-order writeback, in-order retirement
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2.tag0", 64'(dispTag), 64'(0));
    disp(5'd3, 1'b1);
    disp(5'd4, 1'b1);
    wb(3'd1, 32'd7);
    chk("t2.noYoung", 64'(validCommit), 64'(0));
    wb(3'd0, 32'd6);
    chk("t2.noYet", 64'(validCommit), 64'(0));
    tick();
    commit_chk("t2a", 1'b1, 5'd3, 32'd6, 3'd0);
    tick();
    commit_chk("t2b", 1'b1, 5'd4, 32'd7, 3'd1);
    tick();
    chk("t2.idle", 64'(validCommit), 64'(0));
    chk("t2.count", 64'(count), 64'(0));
    // fill, overflow attempt, full-while-retiring, wrap
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 8; i++) disp(5'(i + 1), 1'b1);
    chk("t3.full", 64'(count), 64'(8));
    chk("t3.notReady", 64'(dispReady), 64'(0));
    chk("t3.tailWrap", 64'(dispTag), 64'(0));
    disp(5'd9, 1'b1);
    chk("t3.ignored", 64'(count), 64'(8));
    wb(3'd0, 32'h11);
    chk("t3.stillFull", 64'(count), 64'(8));
    disp(5'd20, 1'b1);
    commit_chk("t3", 1'b1, 5'd1, 32'h11, 3'd0);
    chk("t3.blockedRetire", 64'(count), 64'(7));
    chk("t3.readyAgain", 64'(dispReady), 64'(1));
    chk("t3.nextTag", 64'(dispTag), 64'(0));
    disp(5'd20, 1'b1);
    chk("t3.refill", 64'(count), 64'(8));
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3.flushCount", 64'(count), 64'(0));
    // x0 and non-writing instructions commit without a register write
    disp(5'd0, 1'b1);
    disp(5'd5, 1'b0);
    wb(3'd0, 32'd1);
    wb(3'd1, 32'd2);
    commit_chk("t4a", 1'b0, 5'd0, 32'd1, 3'd0);
    tick();
    commit_chk("t4b", 1'b0, 5'd5, 32'd2, 3'd1);
    // empty buffer: same-cycle dispatch + writeback to new tag must not mark ready
    chk("t5.tag", 64'(dispTag), 64'(2));
    wbValid = 1'b1; wbTag = 3'd2; wbData = 32'd9;
    disp(5'd6, 1'b1);
    wbValid = 1'b0;
    tick();
    tick();
    chk("t5.noCommit", 64'(validCommit), 64'(0));
    chk("t5.count", 64'(count), 64'(1));
    // flush beats dispatch, writeback and a ready head
    disp(5'd7, 1'b1);
    disp(5'd8, 1'b1);
    chk("t6.count3", 64'(count), 64'(3));
    wb(3'd2, 32'd3);
    flush = 1'b1; dispValid = 1'b1; dispDest = 5'd9; wbValid = 1'b1; wbTag = 3'd3; wbData = 32'd4;
    tick();
    flush = 1'b0; dispValid = 1'b0; wbValid = 1'b0;
    chk("t6.count", 64'(count), 64'(0));
    chk("t6.noCommit", 64'(validCommit), 64'(0));
    chk("t6.noWrite", 64'(regWrite), 64'(0));
    chk("t6.tag", 64'(dispTag), 64'(0));
    tick();
    chk("t6.quiet", 64'(validCommit), 64'(0));
    // asynchronous reset with a ready head
    disp(5'd7, 1'b1);
    wb(3'd0, 32'hAB);
    #2 resetN = 1'b0;
    #1;
    chk("t7.validCommit", 64'(validCommit), 64'(0));
    chk("t7.regWrite", 64'(regWrite), 64'(0));
    chk("t7.wraddress", 64'(wraddress), 64'(0));
    chk("t7.wdata", 64'(wdata), 64'(0));
    chk("t7.commitTag", 64'(commitTag), 64'(0));
    chk("t7.count", 64'(count), 64'(0));
    chk("t7.dispReady", 64'(dispReady), 64'(1));
    tick();
    resetN = 1'b1;
    tick();
    chk("t7.noCommitAfter", 64'(validCommit), 64'(0));
    tick();
    chk("t7.noCommitLater", 64'(validCommit), 64'(0));
    chk("t7.countAfter", 64'(count), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
